// File: rtl/wizmap_pkg.sv
// wizmap shared definitions
// config map, CTRL bits, window defaults
package wizmap_pkg;
  localparam int W_ADDR_W = 10;

  localparam logic [3:0] CFG_CTRL   = 4'd0;
  localparam logic [3:0] CFG_HI     = 4'd1;
  localparam logic [3:0] CFG_BTGT   = 4'd2;
  localparam logic [3:0] CFG_BLEN_L = 4'd3;
  localparam logic [3:0] CFG_BLEN_H = 4'd4;
  localparam logic [3:0] CFG_WIN0   = 4'd8;

  localparam int CTRL_A0INV = 0;
  localparam int CTRL_PORTS = 1;
  localparam int CTRL_BTGT9 = 2;
  localparam int CTRL_START = 7;

  localparam logic [4:0] WIN0_RST = 5'b10111;
  localparam logic [4:0] WIN1_RST = 5'b11000;

  typedef enum logic {
    B_IDLE,
    B_ACTIVE
  } bst_e;
endpackage

// File: rtl/wizmap_xlat.sv
// wizmap non-burst translation
// ports, direct and windowed modes
module wizmap_xlat
  import wizmap_pkg::*;
#(
  parameter int NUM_WIN = 2
) (
  input  logic [15:0]                za,
  input  logic                       a0inv,
  input  logic                       ports,
  input  logic [3:0]                 hi,
  input  logic [NUM_WIN-1:0][4:0]    win,
  output logic [W_ADDR_W-1:0]        addr
);
  localparam int IW = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

  logic [IW-1:0] idx;
  logic [4:0]    base;
  logic          a0;

  // select window base, then the mode by priority
  always_comb begin
    idx  = (NUM_WIN > 1) ? za[12 +: IW] : '0;
    base = '0;
    for (int n = 0; n < NUM_WIN; n++) begin
      if (idx == IW'(n)) base = win[n];
    end
    a0 = za[0] ^ a0inv;
    priority case (1'b1)
      ports:   addr = {hi, za[13:9], za[8] ^ a0inv};
      !za[13]: addr = {za[9:1], a0};
      default: addr = {1'b1, za[11:9], base, a0};
    endcase
  end
endmodule

// File: rtl/wizmap_burst.sv
// wizmap_burst: registered W5300 mapper
// with CPU-programmed FIFO burst mode
module wizmap_burst
  import wizmap_pkg::*;
#(
  parameter int          NUM_WIN  = 2,
  parameter int          CNT_W    = 12,
  parameter logic [15:0] BURST_ZA = 16'h00C3
) (
  input  logic                fclk,
  input  logic                rst_n,
  input  logic [15:0]         za,
  input  logic                acc_stb,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [7:0]          cfg_din,
  output logic [7:0]          cfg_dout,
  output logic [9:0]          w5300_addr,
  output logic                addr_vld,
  output logic                burst_active,
  output logic [CNT_W-1:0]    burst_left,
  output logic                burst_done
);
  logic [2:0]             ctrl_q, ctrl_d;
  logic [3:0]             hi_q, hi_d;
  logic [7:0]             btgt_q, btgt_d;
  logic [CNT_W-1:0]       blen_q, blen_d;
  logic [NUM_WIN-1:0][4:0] win_q, win_d;
  bst_e                   st_q, st_d;
  logic [CNT_W-1:0]       left_q, left_d;
  logic                   phase_q, phase_d;
  logic [9:0]             addr_q, addr_d;
  logic                   vld_q, vld_d;
  logic                   done_q, done_d;
  logic [9:0]             xlat_addr;
  logic                   hit;
  logic                   ctrl_wr;
  logic [15:0]            blen_ext;

  wizmap_xlat #(.NUM_WIN(NUM_WIN)) u_xlat (
    .za    (za),
    .a0inv (ctrl_q[CTRL_A0INV]),
    .ports (ctrl_q[CTRL_PORTS]),
    .hi    (hi_q),
    .win   (win_q),
    .addr  (xlat_addr)
  );

  assign blen_ext     = 16'(blen_q);
  assign w5300_addr   = addr_q;
  assign addr_vld     = vld_q;
  assign burst_active = (st_q == B_ACTIVE);
  assign burst_left   = left_q;
  assign burst_done   = done_q;

  // config register writes
  always_comb begin
    ctrl_d = ctrl_q;
    hi_d   = hi_q;
    btgt_d = btgt_q;
    blen_d = blen_q;
    win_d  = win_q;
    if (cfg_we) begin
      case (cfg_addr)
        CFG_CTRL:   ctrl_d = cfg_din[2:0];
        CFG_HI:     hi_d   = cfg_din[3:0];
        CFG_BTGT:   btgt_d = cfg_din;
        CFG_BLEN_L: blen_d[7:0] = cfg_din;
        CFG_BLEN_H: blen_d[CNT_W-1:8] = cfg_din[CNT_W-9:0];
        default: ;
      endcase
      for (int n = 0; n < NUM_WIN; n++) begin
        if (cfg_addr == CFG_WIN0 + 4'(n)) win_d[n] = cfg_din[4:0];
      end
    end
  end

  // config readback
  always_comb begin
    cfg_dout = '0;
    case (cfg_addr)
      CFG_CTRL:   cfg_dout = {burst_active, 4'b0, ctrl_q};
      CFG_HI:     cfg_dout = {4'b0, hi_q};
      CFG_BTGT:   cfg_dout = btgt_q;
      CFG_BLEN_L: cfg_dout = blen_ext[7:0];
      CFG_BLEN_H: cfg_dout = blen_ext[15:8];
      default: ;
    endcase
    for (int n = 0; n < NUM_WIN; n++) begin
      if (cfg_addr == CFG_WIN0 + 4'(n)) cfg_dout = {3'b0, win_q[n]};
    end
  end

  // burst FSM and output address; a CTRL write overrides the access
  always_comb begin
    st_d    = st_q;
    left_d  = left_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    vld_d   = acc_stb;
    done_d  = 1'b0;
    hit     = acc_stb && (st_q == B_ACTIVE) && (za == BURST_ZA);
    ctrl_wr = cfg_we && (cfg_addr == CFG_CTRL);
    if (acc_stb) begin
      addr_d = hit ? {ctrl_q[CTRL_BTGT9], btgt_q,
                      phase_q ^ ctrl_q[CTRL_A0INV]}
                   : xlat_addr;
    end
    if (hit) begin
      left_d  = left_q - 1'b1;
      phase_d = ~phase_q;
      if (left_q == CNT_W'(1)) begin
        st_d   = B_IDLE;
        done_d = 1'b1;
      end
    end
    if (ctrl_wr) begin
      if (cfg_din[CTRL_START]) begin
        if (blen_q != '0) begin
          st_d    = B_ACTIVE;
          left_d  = blen_q;
          phase_d = 1'b0;
        end
      end else begin
        st_d   = B_IDLE;
        left_d = '0;
      end
    end
  end

  // state registers
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      hi_q    <= '0;
      btgt_q  <= '0;
      blen_q  <= '0;
      for (int n = 0; n < NUM_WIN; n++) begin
        win_q[n] <= (n == 0) ? WIN0_RST :
                    (n == 1) ? WIN1_RST : 5'b0;
      end
      st_q    <= B_IDLE;
      left_q  <= '0;
      phase_q <= 1'b0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      hi_q    <= hi_d;
      btgt_q  <= btgt_d;
      blen_q  <= blen_d;
      win_q   <= win_d;
      st_q    <= st_d;
      left_q  <= left_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_wizmap_burst.sv
// tb_wizmap_burst: directed bench
// with address scoreboard
module tb_wizmap_burst;
  logic        fclk;
  logic        rst_n;
  logic [15:0] za;
  logic        acc_stb;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_din;
  logic [7:0]  cfg_dout;
  logic [9:0]  w5300_addr;
  logic        addr_vld;
  logic        burst_active;
  logic [11:0] burst_left;
  logic        burst_done;

  int checks;
  int errors;
  logic [9:0] sb[$];

  wizmap_burst dut (
    .fclk         (fclk),
    .rst_n        (rst_n),
    .za           (za),
    .acc_stb      (acc_stb),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_din      (cfg_din),
    .cfg_dout     (cfg_dout),
    .w5300_addr   (w5300_addr),
    .addr_vld     (addr_vld),
    .burst_active (burst_active),
    .burst_left   (burst_left),
    .burst_done   (burst_done)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp,
                    input string tag);
    cfg_addr = a;
    #1;
    chk(tag, {24'b0, cfg_dout}, {24'b0, exp});
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_din  = d;
    @(negedge fclk);
    cfg_we   = 1'b0;
  endtask

  // strobe one access, push expectation, pop it when addr_vld appears
  task automatic strobe(input logic [15:0] a, input logic [9:0] exp,
                        input string tag);
    za      = a;
    acc_stb = 1'b1;
    sb.push_back(exp);
    @(negedge fclk);
    acc_stb = 1'b0;
    cfg_we  = 1'b0;
    chk({tag, "_vld"}, {31'b0, addr_vld}, 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      chk({tag, "_addr"}, {22'b0, w5300_addr}, {22'b0, sb.pop_front()});
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    za       = '0;
    acc_stb  = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_din  = '0;
    @(negedge fclk);
    chk("rst_addr", {22'b0, w5300_addr}, 32'h0);
    chk("rst_vld", {31'b0, addr_vld}, 32'h0);
    chk("rst_act", {31'b0, burst_active}, 32'h0);
    chk("rst_left", {20'b0, burst_left}, 32'h0);
    chk("rst_done", {31'b0, burst_done}, 32'h0);
    rd(4'd8, 8'h17, "rst_win0");
    rd(4'd9, 8'h18, "rst_win1");
    rd(4'd0, 8'h00, "rst_ctrl");
    rst_n = 1'b1;
    @(negedge fclk);

    strobe(16'h2000, 10'h22E, "win0");
    @(negedge fclk);
    chk("vld_pulse", {31'b0, addr_vld}, 32'h0);
    chk("addr_hold", {22'b0, w5300_addr}, 32'h22E);
    strobe(16'h3000, 10'h230, "win1");

    wr(4'd0, 8'h01);
    strobe(16'h0155, 10'h154, "direct");
    wr(4'd1, 8'h0A);
    rd(4'd1, 8'h0A, "hi_rd");
    wr(4'd0, 8'h03);
    strobe(16'h3E00, 10'h2BF, "ports");

    wr(4'd2, 8'h18);
    wr(4'd3, 8'h04);
    wr(4'd4, 8'h00);
    wr(4'd0, 8'h84);
    chk("b_act", {31'b0, burst_active}, 32'h1);
    chk("b_left4", {20'b0, burst_left}, 32'd4);
    rd(4'd0, 8'h84, "b_ctrl_rd");
    strobe(16'h00C3, 10'h230, "b1");
    chk("b_left3", {20'b0, burst_left}, 32'd3);
    strobe(16'h00C3, 10'h231, "b2");
    chk("b_left2", {20'b0, burst_left}, 32'd2);
    strobe(16'h2000, 10'h22E, "b_other");
    chk("b_other_left", {20'b0, burst_left}, 32'd2);
    strobe(16'h00C3, 10'h230, "b3");
    chk("b_left1", {20'b0, burst_left}, 32'd1);
    chk("b_done_early", {31'b0, burst_done}, 32'h0);
    strobe(16'h00C3, 10'h231, "b4");
    chk("b_left0", {20'b0, burst_left}, 32'd0);
    chk("b_done", {31'b0, burst_done}, 32'h1);
    chk("b_idle", {31'b0, burst_active}, 32'h0);
    @(negedge fclk);
    chk("b_done_pulse", {31'b0, burst_done}, 32'h0);
    strobe(16'h00C3, 10'h0C3, "b5");

    wr(4'd3, 8'h06);
    wr(4'd0, 8'h80);
    chk("ab_left6", {20'b0, burst_left}, 32'd6);
    strobe(16'h00C3, 10'h030, "ab1");
    strobe(16'h00C3, 10'h031, "ab2");
    chk("ab_left4", {20'b0, burst_left}, 32'd4);
    wr(4'd0, 8'h00);
    chk("ab_act", {31'b0, burst_active}, 32'h0);
    chk("ab_left", {20'b0, burst_left}, 32'd0);
    chk("ab_done", {31'b0, burst_done}, 32'h0);
    wr(4'd3, 8'h00);
    wr(4'd0, 8'h80);
    chk("z_act", {31'b0, burst_active}, 32'h0);
    chk("z_done", {31'b0, burst_done}, 32'h0);

    cfg_we   = 1'b1;
    cfg_addr = 4'd8;
    cfg_din  = 8'h01;
    strobe(16'h2000, 10'h22E, "col1");
    strobe(16'h2000, 10'h202, "col2");

    wr(4'd3, 8'h03);
    wr(4'd0, 8'h80);
    chk("mr_left3", {20'b0, burst_left}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_addr", {22'b0, w5300_addr}, 32'h0);
    chk("mr_act", {31'b0, burst_active}, 32'h0);
    chk("mr_left", {20'b0, burst_left}, 32'h0);
    chk("mr_vld", {31'b0, addr_vld}, 32'h0);
    chk("mr_done", {31'b0, burst_done}, 32'h0);
    rd(4'd8, 8'h17, "mr_win0");
    rd(4'd3, 8'h00, "mr_blen");
    rd(4'd2, 8'h00, "mr_btgt");
    rd(4'd1, 8'h00, "mr_hi");
    @(negedge fclk);
    rst_n = 1'b1;
    @(negedge fclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
